alu_op_decoder: RTL

// - Decode stage in front of the ALU: takes 9-bit instruction words and emits the
//   3-bit ALU opcode (kADD..kCLR encoding from package definitions) plus operand fields.
// - Elastic valid/ready on both sides with a 2-entry skid buffer, so in_ready is registered.
// - Illegal opcode 3'b111 is dropped, flagged and counted; legal ops issued are counted.

---
 rtl/alu_op_decoder_if.sv | 58 +++++
 rtl/alu_op_decoder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alu_op_decoder_if.sv
// Handshake bundle between the instruction source, the decoder and the ALU stage.
// Signal names follow the block's established port names.
interface alu_op_decoder_if #(
  parameter int unsigned INSTR_W = 9,
  parameter int unsigned CNT_W   = 16
);

  // Upstream instruction channel
  logic               in_valid;
  logic [INSTR_W-1:0] in_instr;
  logic               in_ready;

  // Downstream decoded-op channel
  logic               out_valid;
  logic [2:0]         out_op;
  logic [2:0]         out_rd;
  logic [2:0]         out_rs;
  logic               out_imm;
  logic               out_ready;

  // Status
  logic               illegal;
  logic [CNT_W-1:0]   issue_cnt;
  logic [CNT_W-1:0]   illegal_cnt;

  // Environment side: drives instructions and ALU-ready, observes everything else
  modport master (
    output in_valid,
    output in_instr,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_op,
    input  out_rd,
    input  out_rs,
    input  out_imm,
    input  illegal,
    input  issue_cnt,
    input  illegal_cnt
  );

  // Decoder side
  modport slave (
    input  in_valid,
    input  in_instr,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_op,
    output out_rd,
    output out_rs,
    output out_imm,
    output illegal,
    output issue_cnt,
    output illegal_cnt
  );

endinterface

// File: rtl/alu_op_decoder.sv
// ALU op decoder: splits 9-bit instruction words into ALU opcode and operand
// fields behind a 2-entry skid buffer. Opcode 3'b111 is dropped, flagged and
// counted; legal ops handed to the ALU are counted.
// Layout is fixed at op[8:6] rd[5:3] rs[2:0]; INSTR_W must be 9.
module alu_op_decoder #(
  parameter int unsigned INSTR_W = 9,
  parameter int unsigned CNT_W   = 16
) (
  input logic             Clk,
  input logic             Reset_n,
  alu_op_decoder_if.slave bus
);

  // ALU opcode encoding
  typedef enum logic [2:0] {
    kAdd = 3'b000,
    kLsh = 3'b001,
    kRsh = 3'b010,
    kSub = 3'b011,
    kAnd = 3'b100,
    kOr  = 3'b101,
    kClr = 3'b110,
    kIll = 3'b111
  } aluOpT;

  // One buffered, already-decoded op
  typedef struct packed {
    logic [2:0] op;
    logic [2:0] rd;
    logic [2:0] rs;
    logic       imm;
  } decEntryT;

  // Buffer occupancy
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b01,
    StFull  = 2'b10
  } bufStateT;

  bufStateT stateQ, stateD;

  decEntryT headQ, headD;
  decEntryT tailQ, tailD;
  decEntryT decoded;

  logic             inReadyQ;
  logic             illegalQ;
  logic [CNT_W-1:0] issueCntQ;
  logic [CNT_W-1:0] illegalCntQ;

  logic [2:0] instrOp;
  logic       accept;
  logic       isLegal;
  logic       push;
  logic       pop;
  logic       illAccept;
  logic       outValid;
  logic       headLoadNew;
  logic       headLoadTail;
  logic       tailLoad;

  // Field extraction and decode of the incoming word
  always_comb begin
    instrOp     = bus.in_instr[INSTR_W-1 -: 3];
    decoded.op  = instrOp;
    decoded.rd  = bus.in_instr[5:3];
    decoded.rs  = (instrOp == kClr) ? 3'b000 : bus.in_instr[2:0];
    decoded.imm = (instrOp == kLsh) || (instrOp == kRsh);
  end

  // Handshake qualification; in_valid gates everything so an X word while idle is inert
  always_comb begin
    accept    = bus.in_valid & inReadyQ;
    isLegal   = (instrOp != kIll);
    push      = accept & isLegal;
    illAccept = accept & ~isLegal;
    pop       = outValid & bus.out_ready;
  end

  // Buffer FSM: state register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      stateQ <= StEmpty;
    end else begin
      stateQ <= stateD;
    end
  end

  // Buffer FSM: next state from push/pop
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StEmpty: begin
        if (push) stateD = StOne;
      end
      StOne: begin
        if (push && !pop)      stateD = StFull;
        else if (pop && !push) stateD = StEmpty;
      end
      StFull: begin
        // in_ready is low while full, so only a pop can happen here
        if (pop) stateD = StOne;
      end
      default: stateD = StEmpty;
    endcase
  end

  // Buffer FSM: output valid and entry load enables
  always_comb begin
    outValid     = 1'b0;
    headLoadNew  = 1'b0;
    headLoadTail = 1'b0;
    tailLoad     = 1'b0;
    unique case (stateQ)
      StEmpty: begin
        headLoadNew = push;
      end
      StOne: begin
        outValid    = 1'b1;
        // With a simultaneous pop the new word replaces the departing head
        headLoadNew = push & pop;
        tailLoad    = push & ~pop;
      end
      StFull: begin
        outValid     = 1'b1;
        headLoadTail = pop;
      end
      default: begin
        outValid = 1'b0;
      end
    endcase
  end

  // Entry next-state muxing
  always_comb begin
    headD = headQ;
    tailD = tailQ;
    if (headLoadNew)  headD = decoded;
    if (headLoadTail) headD = tailQ;
    if (tailLoad)     tailD = decoded;
  end

  // Entry storage; head is what the ALU sees
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      headQ <= '0;
      tailQ <= '0;
    end else begin
      headQ <= headD;
      tailQ <= tailD;
    end
  end

  // in_ready registered from the occupancy we are about to enter
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      inReadyQ <= 1'b1;
    end else begin
      inReadyQ <= (stateD != StFull);
    end
  end

  // Illegal-word pulse and saturating count
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      illegalQ    <= 1'b0;
      illegalCntQ <= '0;
    end else begin
      illegalQ <= illAccept;
      if (illAccept && (illegalCntQ != {CNT_W{1'b1}})) begin
        illegalCntQ <= illegalCntQ + CNT_W'(1);
      end
    end
  end

  // Issued-op count, wraps naturally
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      issueCntQ <= '0;
    end else if (pop) begin
      issueCntQ <= issueCntQ + CNT_W'(1);
    end
  end

  // Port drive
  always_comb begin
    bus.in_ready    = inReadyQ;
    bus.out_valid   = outValid;
    bus.out_op      = headQ.op;
    bus.out_rd      = headQ.rd;
    bus.out_rs      = headQ.rs;
    bus.out_imm     = headQ.imm;
    bus.illegal     = illegalQ;
    bus.issue_cnt   = issueCntQ;
    bus.illegal_cnt = illegalCntQ;
  end

endmodule
